// File: rtl/sub_48_bit_seq_pkg.sv
// Shared widths and FSM encoding for the sliced 48-bit subtractor.
package sub_48_bit_seq_pkg;

  localparam int unsigned N          = 48;
  localparam int unsigned SLICE      = 12;
  localparam int unsigned NUM_SLICES = N / SLICE;
  localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the slice ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_48_bit_seq_sub_slice.sv
// Combinational SLICE-bit ripple adder built from full_adder cells.
module sub_48_bit_seq_sub_slice
  import sub_48_bit_seq_pkg::*;
#(
  parameter int unsigned W = SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[W];

endmodule

// File: rtl/sub_48_bit_seq.sv
// Multi-cycle unsigned subtractor: input1 + ~input2 + 1, one slice per clock,
// with valid/ready handshakes on both sides.
module sub_48_bit_seq
  import sub_48_bit_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] answer,
  output logic         borrow_out,
  output logic         zero
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [N-1:0]       op_a_q, op_a_d;
  logic [N-1:0]       op_b_q, op_b_d;
  logic [N-1:0]       answer_q, answer_d;
  logic               borrow_q, borrow_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  int unsigned        slice_base;
  logic [SLICE-1:0]   slice_a;
  logic [SLICE-1:0]   slice_b;
  logic [SLICE-1:0]   slice_sum;
  logic               slice_cout;

  // Select the operand chunk addressed by the slice counter.
  always_comb begin
    slice_base = 32'(cnt_q) * SLICE;
    slice_a    = op_a_q[slice_base +: SLICE];
    slice_b    = op_b_q[slice_base +: SLICE];
  end

  sub_48_bit_seq_sub_slice #(
    .W (SLICE)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    answer_d    = answer_q;
    borrow_d    = borrow_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          op_a_d     = input1;
          op_b_d     = ~input2;
          carry_d    = 1'b1;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end

      BUSY: begin
        answer_d[slice_base +: SLICE] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_SLICES - 1)) begin
          // Final carry of 0 means the subtrahend was larger.
          borrow_d    = ~slice_cout;
          zero_d      = (answer_d == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      answer_q    <= '0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      answer_q    <= answer_d;
      borrow_q    <= borrow_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign answer     = answer_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_sub_48_bit_seq.sv
// Directed and random-pair bench for the sliced 48-bit subtractor.
module tb_sub_48_bit_seq;
  import sub_48_bit_seq_pkg::*;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] input1;
  logic [N-1:0] input2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] answer;
  logic         borrow_out;
  logic         zero;

  int n_vec  = 0;
  int n_miss = 0;

  sub_48_bit_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .input1     (input1),
    .input2     (input2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .answer     (answer),
    .borrow_out (borrow_out),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check latency, result, flags and return to idle.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_ans, input logic exp_borrow, input logic exp_zero);
    int lat;
    int wait_cyc;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, N'(in_ready), N'(1));
    input1   = a;
    input2   = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    input1   = ~a;
    input2   = a ^ b;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, N'(lat), N'(NUM_SLICES));
    check({tag, "_answer"}, answer, exp_ans);
    check({tag, "_borrow"}, N'(borrow_out), N'(exp_borrow));
    check({tag, "_zero"}, N'(zero), N'(exp_zero));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, N'({out_valid, in_ready}), N'(2'b01));
  endtask

  initial begin
    logic [N-1:0] a, b, exp, held;
    logic         seen_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    input1    = '0;
    input2    = '0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_in_ready", N'(in_ready), N'(1));
    check("reset_out_valid", N'(out_valid), N'(0));
    check("reset_answer", answer, '0);
    check("reset_flags", N'({borrow_out, zero}), N'(0));

    // Reset two cycles into BUSY discards the operation.
    input1   = 48'h000000000100;
    input2   = 48'h000000000001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy_in_ready", N'(in_ready), N'(1));
    check("rst_busy_out_valid", N'(out_valid), N'(0));
    check("rst_busy_answer", answer, '0);
    check("rst_busy_flags", N'({borrow_out, zero}), N'(0));
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("rst_busy_no_result", N'(seen_valid), N'(0));

    run_op("basic", 48'h000000000100, 48'h000000000001, 48'h0000000000FF, 1'b0, 1'b0);
    run_op("wrap", 48'h0, 48'h1, 48'hFFFFFFFFFFFF, 1'b1, 1'b0);
    run_op("equal", 48'hABCDEF123456, 48'hABCDEF123456, 48'h0, 1'b0, 1'b1);
    run_op("zero_zero", 48'h0, 48'h0, 48'h0, 1'b0, 1'b1);
    run_op("chain", 48'h001000000000, 48'h000000000001, 48'h000FFFFFFFFF, 1'b0, 1'b0);
    run_op("max_min", 48'hFFFFFFFFFFFF, 48'h000000000001, 48'hFFFFFFFFFFFE, 1'b0, 1'b0);
    run_op("min_max", 48'h000000000001, 48'hFFFFFFFFFFFF, 48'h000000000002, 1'b1, 1'b0);
    run_op("slice_edge", 48'h000000001000, 48'h000000000FFF, 48'h000000000001, 1'b0, 1'b0);

    // Backpressure: result held in DONE while new requests are ignored.
    input1   = 48'h123456789ABC;
    input2   = 48'h000000000ABC;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < NUM_SLICES; i++) tick();
    check("bp_valid", N'(out_valid), N'(1));
    held     = answer;
    check("bp_answer", held, 48'h123456789000);
    input1   = 48'h1;
    input2   = 48'h2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", N'({out_valid, in_ready}), N'(2'b10));
      check("bp_hold_answer", answer, 48'h123456789000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", N'({out_valid, in_ready}), N'(2'b01));

    // Random pairs against a native-arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      a = N'({$urandom(), $urandom()});
      b = N'({$urandom(), $urandom()});
      if (i % 50 == 0) b = a;
      exp = a - b;
      run_op("rand", a, b, exp, a < b, exp == '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
